// File: rtl/ccu_ar_arbiter.sv
// Round-robin AR arbiter for NumReq cores sharing one downstream AXI read port.
// One transaction in flight; R beats are routed back to the granted core only.
module ccu_ar_arbiter #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    localparam int unsigned IdxW     = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int unsigned OutIdW   = IdWidth + IdxW
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    // Upstream AR channels
    input  logic [NumReq-1:0]             req_ar_valid_i,
    output logic [NumReq-1:0]             req_ar_ready_o,
    input  logic [NumReq*AddrWidth-1:0]   req_ar_addr_i,
    input  logic [NumReq*IdWidth-1:0]     req_ar_id_i,
    input  logic [NumReq*8-1:0]           req_ar_len_i,
    // Downstream AR channel
    output logic                          mst_ar_valid_o,
    input  logic                          mst_ar_ready_i,
    output logic [AddrWidth-1:0]          mst_ar_addr_o,
    output logic [OutIdW-1:0]             mst_ar_id_o,
    output logic [7:0]                    mst_ar_len_o,
    // Downstream R channel
    input  logic                          mst_r_valid_i,
    output logic                          mst_r_ready_o,
    input  logic                          mst_r_last_i,
    input  logic [DataWidth-1:0]          mst_r_data_i,
    // Upstream R channels
    output logic [NumReq-1:0]             req_r_valid_o,
    input  logic [NumReq-1:0]             req_r_ready_i,
    output logic                          req_r_last_o,
    output logic [DataWidth-1:0]          req_r_data_o,
    output logic                          len_err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [IdxW-1:0]      rr_q, rr_d;
    logic [IdxW-1:0]      grant_q, grant_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 len_err_q, len_err_d;

    logic                 arb_found;
    logic [IdxW-1:0]      arb_idx;
    logic [IdxW:0]        cand_w;
    logic [AddrWidth-1:0] sel_addr;
    logic [IdWidth-1:0]   sel_id;
    logic [7:0]           sel_len;
    logic                 r_hs;

    // Round-robin search: first valid requester at rr_q, rr_q+1, ... modulo NumReq.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_w    = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand_w = {1'b0, rr_q} + (IdxW+1)'(k);
            if (cand_w >= (IdxW+1)'(NumReq)) begin
                cand_w = cand_w - (IdxW+1)'(NumReq);
            end
            if (!arb_found && req_ar_valid_i[cand_w[IdxW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand_w[IdxW-1:0];
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_id   = '0;
        sel_len  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (arb_idx == IdxW'(i)) begin
                sel_addr = req_ar_addr_i[i*AddrWidth +: AddrWidth];
                sel_id   = req_ar_id_i[i*IdWidth +: IdWidth];
                sel_len  = req_ar_len_i[i*8 +: 8];
            end
        end
    end

    assign r_hs = (state_q == ST_DATA) && mst_r_valid_i && req_r_ready_i[grant_q];

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        id_d      = id_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        len_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d = ST_ADDR;
                    grant_d = arb_idx;
                    addr_d  = sel_addr;
                    id_d    = sel_id;
                    len_d   = sel_len;
                    rr_d    = (arb_idx == IdxW'(NumReq - 1)) ? '0 : arb_idx + 1'b1;
                end
            end
            ST_ADDR: begin
                if (mst_ar_ready_i) begin
                    state_d = ST_DATA;
                    cnt_d   = len_q;
                end
            end
            ST_DATA: begin
                // A mismatched last still terminates; a surplus beat parks the counter at 0.
                if (r_hs) begin
                    if (mst_r_last_i) begin
                        state_d   = ST_IDLE;
                        len_err_d = (cnt_q != 8'd0);
                        cnt_d     = '0;
                    end else if (cnt_q == 8'd0) begin
                        len_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            rr_q      <= '0;
            grant_q   <= '0;
            addr_q    <= '0;
            id_q      <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    // Handshake-bearing outputs are masked while rst_i is high so an abandoned
    // transaction can never complete a handshake or flag an error on its way out.
    always_comb begin
        req_ar_ready_o = '0;
        req_r_valid_o  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            req_ar_ready_o[i] = !rst_i && (state_q == ST_IDLE) && arb_found
                                && (arb_idx == IdxW'(i));
            req_r_valid_o[i]  = !rst_i && (state_q == ST_DATA) && mst_r_valid_i
                                && (grant_q == IdxW'(i));
        end
    end

    assign mst_ar_valid_o = !rst_i && (state_q == ST_ADDR);
    assign mst_ar_addr_o  = rst_i ? '0 : addr_q;
    assign mst_ar_id_o    = rst_i ? '0 : {grant_q, id_q};
    assign mst_ar_len_o   = rst_i ? '0 : len_q;
    assign mst_r_ready_o  = !rst_i && (state_q == ST_DATA) && req_r_ready_i[grant_q];
    assign req_r_data_o   = mst_r_data_i;
    assign req_r_last_o   = mst_r_last_i;
    assign len_err_o      = !rst_i && len_err_q;

endmodule

// File: tb/tb_ccu_ar_arbiter.sv
// Bench for ccu_ar_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ccu_ar_arbiter;

    localparam int N  = 2;
    localparam int IW = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int OW = IW + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      ar_valid;
    logic [N-1:0]      ar_ready;
    logic [N*AW-1:0]   ar_addr;
    logic [N*IW-1:0]   ar_id;
    logic [N*8-1:0]    ar_len;
    logic              m_ar_valid;
    logic              m_ar_ready;
    logic [AW-1:0]     m_ar_addr;
    logic [OW-1:0]     m_ar_id;
    logic [7:0]        m_ar_len;
    logic              m_r_valid;
    logic              m_r_ready;
    logic              m_r_last;
    logic [DW-1:0]     m_r_data;
    logic [N-1:0]      r_valid;
    logic [N-1:0]      r_ready;
    logic              r_last;
    logic [DW-1:0]     r_data;
    logic              len_err;

    ccu_ar_arbiter #(.NumReq(N), .IdWidth(IW), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_ar_valid_i(ar_valid), .req_ar_ready_o(ar_ready),
        .req_ar_addr_i(ar_addr), .req_ar_id_i(ar_id), .req_ar_len_i(ar_len),
        .mst_ar_valid_o(m_ar_valid), .mst_ar_ready_i(m_ar_ready),
        .mst_ar_addr_o(m_ar_addr), .mst_ar_id_o(m_ar_id), .mst_ar_len_o(m_ar_len),
        .mst_r_valid_i(m_r_valid), .mst_r_ready_o(m_r_ready),
        .mst_r_last_i(m_r_last), .mst_r_data_i(m_r_data),
        .req_r_valid_o(r_valid), .req_r_ready_i(r_ready),
        .req_r_last_o(r_last), .req_r_data_o(r_data),
        .len_err_o(len_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Transaction-level model: is a request granted, has its AR been issued,
    // how many beats have been seen, and is an error flag owed next cycle.
    bit          m_busy   = 1'b0;
    bit          m_issued = 1'b0;
    int          m_g      = 0;
    int          m_rr     = 0;
    int          m_seen   = 0;
    bit          m_err    = 1'b0;
    logic [63:0] m_addr   = '0;
    logic [3:0]  m_id     = '0;
    logic [7:0]  m_len    = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) begin
            int c = (rr + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic compare_all();
        logic [N-1:0]  e_ready = '0;
        logic [N-1:0]  e_rvalid = '0;
        logic          e_arvalid = 1'b0;
        logic          e_rready = 1'b0;
        logic [63:0]   e_addr = '0;
        logic [OW-1:0] e_id = '0;
        logic [7:0]    e_len = '0;
        logic          e_err = 1'b0;
        int g;
        if (!rst) begin
            if (!m_busy) begin
                g = pick(ar_valid, m_rr);
                if (g >= 0) e_ready = N'(1 << g);
            end else if (!m_issued) begin
                e_arvalid = 1'b1;
            end else begin
                e_rready = r_ready[m_g];
                e_rvalid = m_r_valid ? N'(1 << m_g) : '0;
            end
            e_addr = m_addr;
            e_id   = OW'((m_g << IW) | int'(m_id));
            e_len  = m_len;
            e_err  = m_err;
        end
        chk("ar_ready", 64'(ar_ready), 64'(e_ready));
        chk("mst_ar_valid", 64'(m_ar_valid), 64'(e_arvalid));
        chk("mst_ar_addr", m_ar_addr, e_addr);
        chk("mst_ar_id", 64'(m_ar_id), 64'(e_id));
        chk("mst_ar_len", 64'(m_ar_len), 64'(e_len));
        chk("mst_r_ready", 64'(m_r_ready), 64'(e_rready));
        chk("req_r_valid", 64'(r_valid), 64'(e_rvalid));
        chk("req_r_data", r_data, m_r_data);
        chk("req_r_last", 64'(r_last), 64'(m_r_last));
        chk("len_err", 64'(len_err), 64'(e_err));
    endtask

    task automatic update_model();
        int g;
        bit nerr = 1'b0;
        if (rst) begin
            m_busy = 0; m_issued = 0; m_g = 0; m_rr = 0; m_seen = 0; m_err = 0;
            m_addr = '0; m_id = '0; m_len = '0;
            return;
        end
        if (!m_busy) begin
            g = pick(ar_valid, m_rr);
            if (g >= 0) begin
                m_g = g;
                m_addr = ar_addr[g*AW +: AW];
                m_id   = ar_id[g*IW +: IW];
                m_len  = ar_len[g*8 +: 8];
                m_rr   = (g + 1) % N;
                m_busy = 1; m_issued = 0;
            end
        end else if (!m_issued) begin
            if (m_ar_ready) begin
                m_issued = 1; m_seen = 0;
            end
        end else if (m_r_valid && r_ready[m_g]) begin
            if (m_r_last) begin
                nerr = (m_seen < int'(m_len));
                m_busy = 0;
            end else begin
                nerr = (m_seen >= int'(m_len));
            end
            m_seen++;
        end
        m_err = nerr;
    endtask

    task automatic settle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic adv();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [3:0] id, input logic [7:0] len);
        ar_addr[i*AW +: AW] = a;
        ar_id[i*IW +: IW]   = id;
        ar_len[i*8 +: 8]    = len;
    endtask

    logic [N-1:0] exp_grant [4];

    initial begin
        rst = 1'b1; ar_valid = '1; ar_addr = '0; ar_id = '0; ar_len = '0;
        m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_last = 1'b0; m_r_data = '0; r_ready = '0;

        // Reset: no acceptance even with every core requesting
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("rst_ar_ready", 64'(ar_ready), 64'h0);
            chk("rst_mst_ar_valid", 64'(m_ar_valid), 64'h0);
            adv();
        end
        rst = 1'b0; ar_valid = '0;

        // Single request from core 1
        set_req(1, 64'h8004_0000, 4'd3, 8'd3);
        ar_valid = 2'b10; r_ready = 2'b11;
        settle(); chk("t1_grant", 64'(ar_ready), 64'h2); adv();
        ar_valid = '0; m_ar_ready = 1'b1;
        settle();
        chk("t1_ar_id", 64'(m_ar_id), 64'h13);
        chk("t1_ar_addr", m_ar_addr, 64'h8004_0000);
        chk("t1_ar_len", 64'(m_ar_len), 64'h3);
        adv();
        m_ar_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            m_r_valid = 1'b1; m_r_last = (b == 3); m_r_data = {$urandom, $urandom};
            settle(); chk("t1_r_valid", 64'(r_valid), 64'h2); adv();
        end
        m_r_valid = 1'b0; m_r_last = 1'b0;
        settle(); chk("t1_len_err", 64'(len_err), 64'h0); adv();

        // Contention: grants must alternate 0,1,0,1 from reset
        rst = 1'b1; step(); rst = 1'b0;
        set_req(0, 64'h1000, 4'd1, 8'd0);
        set_req(1, 64'h2000, 4'd2, 8'd0);
        ar_valid = 2'b11; m_ar_ready = 1'b1; m_r_valid = 1'b1; m_r_last = 1'b1;
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
        for (int t = 0; t < 4; t++) begin
            settle(); chk("rr_grant", 64'(ar_ready), 64'(exp_grant[t])); adv();
            step();
            step();
        end
        ar_valid = '0; m_r_valid = 1'b0; m_r_last = 1'b0; m_ar_ready = 1'b0;

        // Backpressure on AR and on core 0's R ready
        set_req(0, 64'hDEAD_BEEF_0000_0040, 4'd5, 8'd1);
        ar_valid = 2'b01;
        step();
        ar_valid = '0;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("bp_ar_valid", 64'(m_ar_valid), 64'h1);
            chk("bp_ar_addr", m_ar_addr, 64'hDEAD_BEEF_0000_0040);
            adv();
        end
        m_ar_ready = 1'b1; step(); m_ar_ready = 1'b0;
        r_ready = 2'b10; m_r_valid = 1'b1;
        settle();
        chk("bp_r_ready", 64'(m_r_ready), 64'h0);
        chk("bp_r_valid", 64'(r_valid), 64'h1);
        adv();
        r_ready = 2'b11; step();
        m_r_last = 1'b1; step();
        m_r_valid = 1'b0; m_r_last = 1'b0;

        // Early last: len=3 but last on the third beat
        set_req(1, 64'h3000, 4'd7, 8'd3);
        ar_valid = 2'b10; step(); ar_valid = '0;
        m_ar_ready = 1'b1; step(); m_ar_ready = 1'b0;
        m_r_valid = 1'b1;
        step(); step();
        m_r_last = 1'b1; step();
        m_r_valid = 1'b0; m_r_last = 1'b0;
        settle(); chk("le_pulse", 64'(len_err), 64'h1); adv();
        settle(); chk("le_pulse_end", 64'(len_err), 64'h0); adv();

        // Reset after one of four beats, then core 0 wins a tie
        set_req(0, 64'h4000, 4'd9, 8'd3);
        ar_valid = 2'b01; step(); ar_valid = '0;
        m_ar_ready = 1'b1; step(); m_ar_ready = 1'b0;
        m_r_valid = 1'b1; step();
        rst = 1'b1;
        settle();
        chk("rst_mid_r_valid", 64'(r_valid), 64'h0);
        chk("rst_mid_r_ready", 64'(m_r_ready), 64'h0);
        adv();
        rst = 1'b0; m_r_valid = 1'b0; ar_valid = 2'b11;
        settle();
        chk("rst_mid_grant", 64'(ar_ready), 64'h1);
        chk("rst_mid_ar_valid", 64'(m_ar_valid), 64'h0);
        adv();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            ar_valid = N'($urandom);
            for (int i = 0; i < N; i++)
                set_req(i, {$urandom, $urandom}, 4'($urandom), 8'($urandom_range(0, 3)));
            m_ar_ready = ($urandom_range(0, 2) != 0);
            m_r_valid  = ($urandom_range(0, 3) != 0);
            r_ready    = N'($urandom);
            m_r_data   = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) m_r_last = 1'($urandom);
            else m_r_last = (m_busy && m_issued && m_seen >= int'(m_len));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
